// File: rtl/vend_pkg.sv
// Shared types and helpers for the vend_ctrl drink-vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PAY    = 3'd2,
    S_BREW   = 3'd3,
    S_FAIL   = 3'd4,
    S_CHANGE = 3'd5
  } state_e;

  localparam logic [3:0] LED_IDLE   = 4'b1111;
  localparam logic [3:0] LED_SELECT = 4'b0011;
  localparam logic [3:0] LED_PAY    = 4'b0001;
  localparam logic [3:0] LED_OFF    = 4'b0000;
  localparam logic [3:0] BLANK_ALL  = 4'b1111;

  // Double-dabble: returns {hundreds, tens, units}.
  function automatic logic [11:0] bcd3(input logic [7:0] v);
    logic [19:0] s;
    s = {12'd0, v};
    for (int i = 0; i < 8; i++) begin
      if (s[11:8] >= 4'd5)  s[11:8]  = s[11:8] + 4'd3;
      if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
      if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
      s = {s[18:0], 1'b0};
    end
    return s[19:8];
  endfunction

endpackage

// File: rtl/vend_debounce.sv
// Single-button debouncer: accepts a raw level after DEBOUNCE_CYC identical
// samples and emits a one-cycle press pulse on each accepted 1->0 transition.
module vend_debounce #(
  parameter int DEBOUNCE_CYC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q, prev_d;
  logic             press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Counting only while raw differs from the accepted level means any
    // sample matching the old level restarts the window.
    if (btn_n != level_q) begin
      if (cnt_q == CNT_LAST) level_d = btn_n;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    prev_d  = level_q;
    press_d = prev_q & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/vend_ctrl.sv
// Drink-vending controller: button debounce, idle/select/pay/brew/fail FSM,
// status LEDs and BCD display image. Define VEND_CHANGE_EN for change return.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                      NUM_DRINKS   = 4,
  parameter logic [NUM_DRINKS*8-1:0] PRICES       = {8'd50, 8'd35, 8'd20, 8'd10},
  parameter int                      MONEY_STEP   = 5,
  parameter int                      MONEY_MAX    = 50,
  parameter int                      DEBOUNCE_CYC = 100,
  parameter int                      BLINK_CYC    = 16666667,
  parameter int                      TICK_CYC     = 20000000,
  parameter int                      FAIL_CYC     = 200000000,
  parameter int                      CHANGE_CYC   = 100000000,
  localparam int                     SEL_W        = $clog2(NUM_DRINKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_cancel_n,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             btn_select_n,
  output logic [2:0]       state,
  output logic [SEL_W-1:0] sel,
  output logic [7:0]       money,
  output logic [6:0]       percent,
  output logic [3:0]       led,
  output logic [15:0]      disp_bcd,
  output logic [3:0]       disp_blank,
  output logic             vend_start,
  output logic             vend_done
);

  localparam logic [31:0]      BLINK_LAST  = 32'(BLINK_CYC - 1);
  localparam logic [31:0]      TICK_LAST   = 32'(TICK_CYC - 1);
  localparam logic [31:0]      FAIL_LAST   = 32'(FAIL_CYC - 1);
  localparam logic [31:0]      CHANGE_LAST = 32'(CHANGE_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_DRINKS - 1);

  logic       p_cancel, p_left, p_right, p_select;
  logic [3:0] btn_lvl_unused;

  vend_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_cancel (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_cancel_n), .level(btn_lvl_unused[3]), .press(p_cancel));
  vend_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_select (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_select_n), .level(btn_lvl_unused[2]), .press(p_select));
  vend_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_right_n), .level(btn_lvl_unused[1]), .press(p_right));
  vend_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_left_n), .level(btn_lvl_unused[0]), .press(p_left));

  logic ev_cancel, ev_select, ev_right, ev_left, ev_any;

  assign ev_cancel = p_cancel;
  assign ev_select = p_select & ~p_cancel;
  assign ev_right  = p_right & ~p_cancel & ~p_select;
  assign ev_left   = p_left & ~p_cancel & ~p_select & ~p_right;
  assign ev_any    = ev_cancel | ev_select | ev_right | ev_left;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       money_q, money_d;
  logic [6:0]       percent_q, percent_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      blink_q, blink_d;
  logic [3:0]       led_q, led_d;
  logic [15:0]      disp_bcd_q, disp_bcd_d;
  logic [3:0]       disp_blank_q, disp_blank_d;
  logic             vend_start_q, vend_start_d;
  logic             vend_done_q, vend_done_d;

  logic [7:0] price_sel;
  logic [7:0] disp_val;
  logic       disp_on;

  assign price_sel = PRICES[{sel_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    money_d   = money_q;
    percent_d = percent_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE: begin
        sel_d     = '0;
        money_d   = '0;
        percent_d = '0;
        timer_d   = '0;
        if (ev_any) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (ev_cancel)      state_d = S_IDLE;
        else if (ev_select) state_d = S_PAY;
        else if (ev_right)  sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        else if (ev_left)   sel_d = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
      end
      S_PAY: begin
        timer_d = '0;
        if (ev_cancel) state_d = S_IDLE;
        else if (ev_select) begin
          percent_d = '0;
          state_d   = (money_q >= price_sel) ? S_BREW : S_FAIL;
        end else if (ev_right) begin
          if (int'(money_q) + MONEY_STEP <= MONEY_MAX) money_d = money_q + 8'(MONEY_STEP);
        end else if (ev_left) begin
          if (int'(money_q) >= MONEY_STEP) money_d = money_q - 8'(MONEY_STEP);
        end
      end
      S_BREW: begin
        if (timer_q == TICK_LAST) begin
          timer_d = '0;
          if (percent_q == 7'd100) begin
`ifdef VEND_CHANGE_EN
            state_d = S_CHANGE;
`else
            state_d = S_IDLE;
`endif
          end else begin
            percent_d = percent_q + 7'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_FAIL: begin
        if (timer_q == FAIL_LAST) state_d = S_IDLE;
        else                      timer_d = timer_q + 32'd1;
      end
      S_CHANGE: begin
        if (timer_q == CHANGE_LAST) state_d = S_IDLE;
        else                        timer_d = timer_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LEDs and vend pulses follow the next state so they line up with state.
  always_comb begin
    blink_d = '0;
    led_d   = LED_OFF;
    case (state_d)
      S_IDLE: begin
        if (state_q != S_IDLE) begin
          led_d = LED_IDLE;
        end else if (blink_q == BLINK_LAST) begin
          led_d = ~led_q;
        end else begin
          led_d   = led_q;
          blink_d = blink_q + 32'd1;
        end
      end
      S_SELECT: led_d = LED_SELECT;
      S_PAY:    led_d = LED_PAY;
      default:  led_d = LED_OFF;
    endcase
    vend_start_d = (state_d == S_BREW) && (state_q != S_BREW);
    vend_done_d  = (state_d == S_BREW) && (percent_d == 7'd100) && (timer_d == TICK_LAST);
  end

  // Display image is derived from registered state, giving a one-cycle lag.
  always_comb begin
    disp_val = 8'd0;
    disp_on  = 1'b1;
    case (state_q)
      S_SELECT: disp_val = 8'(sel_q) + 8'd1;
      S_PAY:    disp_val = money_q;
      S_BREW:   disp_val = {1'b0, percent_q};
      S_FAIL:   disp_val = price_sel;
      S_CHANGE: disp_val = money_q - price_sel;
      default:  disp_on  = 1'b0;
    endcase
    disp_bcd_d   = 16'h0000;
    disp_blank_d = BLANK_ALL;
    if (disp_on) begin
      disp_bcd_d   = {4'h0, bcd3(disp_val)};
      disp_blank_d = {1'b0, disp_val < 8'd10, disp_val < 8'd100, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      money_q      <= '0;
      percent_q    <= '0;
      timer_q      <= '0;
      blink_q      <= '0;
      led_q        <= LED_IDLE;
      disp_bcd_q   <= 16'h0000;
      disp_blank_q <= BLANK_ALL;
      vend_start_q <= 1'b0;
      vend_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      money_q      <= money_d;
      percent_q    <= percent_d;
      timer_q      <= timer_d;
      blink_q      <= blink_d;
      led_q        <= led_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_blank_q <= disp_blank_d;
      vend_start_q <= vend_start_d;
      vend_done_q  <= vend_done_d;
    end
  end

  assign state      = state_q;
  assign sel        = sel_q;
  assign money      = money_q;
  assign percent    = percent_q;
  assign led        = led_q;
  assign disp_bcd   = disp_bcd_q;
  assign disp_blank = disp_blank_q;
  assign vend_start = vend_start_q;
  assign vend_done  = vend_done_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl with short timing parameters.
module tb_vend_ctrl;

  localparam int DEB = 4;
  localparam logic [3:0] B_LEFT  = 4'b0001;
  localparam logic [3:0] B_RIGHT = 4'b0010;
  localparam logic [3:0] B_SEL   = 4'b0100;
  localparam logic [3:0] B_CAN   = 4'b1000;

  logic        clk, rst_n;
  logic        btn_cancel_n, btn_left_n, btn_right_n, btn_select_n;
  logic [2:0]  state;
  logic [1:0]  sel;
  logic [7:0]  money;
  logic [6:0]  percent;
  logic [3:0]  led;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_blank;
  logic        vend_start, vend_done;

  int n_checks = 0;
  int n_fail   = 0;

  vend_ctrl #(
    .NUM_DRINKS(4), .PRICES({8'd50, 8'd35, 8'd20, 8'd10}), .MONEY_STEP(5), .MONEY_MAX(50),
    .DEBOUNCE_CYC(DEB), .BLINK_CYC(8), .TICK_CYC(2), .FAIL_CYC(20), .CHANGE_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_cancel_n(btn_cancel_n), .btn_left_n(btn_left_n),
    .btn_right_n(btn_right_n), .btn_select_n(btn_select_n),
    .state(state), .sel(sel), .money(money), .percent(percent), .led(led),
    .disp_bcd(disp_bcd), .disp_blank(disp_blank),
    .vend_start(vend_start), .vend_done(vend_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    btn_cancel_n = ~m[3];
    btn_select_n = ~m[2];
    btn_right_n  = ~m[1];
    btn_left_n   = ~m[0];
    repeat (8) @(posedge clk);
    @(negedge clk);
    {btn_cancel_n, btn_select_n, btn_right_n, btn_left_n} = 4'b1111;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse/brew monitor
  int         n_start = 0, n_done = 0, brew_cyc = 0;
  logic [6:0] pct_at_done = '0;
  logic [2:0] st_at_start = '0, st_before_start = '0, st_after_done = '0, st_prev = '0;
  logic       done_prev = 1'b0, saw_100 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (vend_start) begin
        n_start         <= n_start + 1;
        st_at_start     <= state;
        st_before_start <= st_prev;
      end
      if (done_prev) st_after_done <= state;
      done_prev <= vend_done;
      if (vend_done) begin
        n_done      <= n_done + 1;
        pct_at_done <= percent;
      end
      if (state == 3'd3) brew_cyc <= brew_cyc + 1;
      if (disp_bcd == 16'h0100 && disp_blank == 4'b0001) saw_100 <= 1'b1;
      st_prev <= state;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"}, state, 0);
    check({pfx, "_sel"}, sel, 0);
    check({pfx, "_money"}, money, 0);
    check({pfx, "_percent"}, percent, 0);
    check({pfx, "_led"}, led, 4'b1111);
    check({pfx, "_disp_bcd"}, disp_bcd, 0);
    check({pfx, "_disp_blank"}, disp_blank, 4'b1111);
    check({pfx, "_vend_start"}, vend_start, 0);
    check({pfx, "_vend_done"}, vend_done, 0);
  endtask

  task automatic go_to_brew;
    press(B_RIGHT);
    press_n(B_RIGHT, 2);
    press(B_SEL);
    press_n(B_RIGHT, 7);
    check("pay_money_35", money, 35);
    press(B_SEL);
  endtask

  initial begin
    int k;
    logic [2:0] st_exit;
    {btn_cancel_n, btn_select_n, btn_right_n, btn_left_n} = 4'b1111;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Idle blink: toggles after BLINK_CYC cycles
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("blink_before", led, 4'b1111);
    cycle();
    check("blink_after", led, 4'b0000);

    // Bounce: 3 low samples then release
    btn_right_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_right_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bounce_no_event", state, 0);

    // Held press: state changes on edge DEB+2
    btn_right_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold_state_edge5", state, 0);
    cycle();
    check("hold_state_edge6", state, 1);
    check("select_led", led, 4'b0011);
    check("disp_lag_blank", disp_blank, 4'b1111);
    cycle();
    check("select_disp_bcd", disp_bcd, 16'h0001);
    check("select_disp_blank", disp_blank, 4'b0111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_right_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);

    // SELECT wrap and priority
    press(B_LEFT);
    check("sel_wrap_down", sel, 3);
    check("sel_wrap_disp", disp_bcd, 16'h0004);
    press(B_RIGHT);
    check("sel_wrap_up", sel, 0);
    press(B_SEL | B_CAN);
    check("cancel_priority", state, 0);

    // PAY saturation and floor
    press(B_RIGHT);
    press_n(B_RIGHT, 2);
    check("sel_is_2", sel, 2);
    press(B_SEL);
    check("pay_state", state, 2);
    check("pay_led", led, 4'b0001);
    check("pay_zero_bcd", disp_bcd, 16'h0000);
    check("pay_zero_blank", disp_blank, 4'b0111);
    press_n(B_RIGHT, 11);
    check("money_sat", money, 50);
    check("money_sat_bcd", disp_bcd, 16'h0050);
    check("money_sat_blank", disp_blank, 4'b0011);
    press_n(B_LEFT, 11);
    check("money_floor", money, 0);

    // Insufficient money -> FAIL
    press_n(B_RIGHT, 6);
    check("money_30", money, 30);
    press(B_SEL);
    check("fail_state", state, 4);
    check("fail_led", led, 4'b0000);
    check("fail_disp_bcd", disp_bcd, 16'h0035);
    check("fail_disp_blank", disp_blank, 4'b0011);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("fail_still", state, 4);
    cycle();
    check("fail_to_idle", state, 0);
    check("idle_entry_led", led, 4'b1111);

    // Full brew
    go_to_brew();
    check("brew_state", state, 3);
    check("start_count", n_start, 1);
    check("start_in_brew", st_at_start, 3);
    check("start_first_cycle", st_before_start, 2);
    k = 0;
    while (state == 3'd3 && k < 400) begin
      cycle();
      k++;
    end
    check("brew_exit_in_time", (k < 400), 1);
    st_exit = state;
    cycle();
    check("brew_cycles", brew_cyc, 202);
    check("done_count", n_done, 1);
    check("done_at_100", pct_at_done, 100);
    check("disp_100_seen", saw_100, 1);
`ifdef VEND_CHANGE_EN
    check("exit_state", st_exit, 5);
    check("done_last_cycle", st_after_done, 5);
    check("change_bcd", disp_bcd, 16'h0000);
    check("change_blank", disp_blank, 4'b0111);
    k = 0;
    while (state != 3'd0 && k < 40) begin
      cycle();
      k++;
    end
    check("change_to_idle", state, 0);
`else
    check("exit_state", st_exit, 0);
    check("done_last_cycle", st_after_done, 0);
    check("idle_blank", disp_blank, 4'b1111);
`endif

    // Reset in the middle of a brew
    go_to_brew();
    k = 0;
    while (percent != 7'd57 && k < 200) begin
      cycle();
      k++;
    end
    check("reach_pct57", percent, 57);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
